// File: rtl/picosoc_iomem_timer.sv
// Down-counting timer/interrupt peripheral on the PicoSoC iomem bus (256-byte window, level irq).
// Optional free-running cycle counter at offset 0x14 when PICOSOC_TIMER_CYCLES_EN is defined.
module picosoc_iomem_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  typedef enum logic [5:0] {
    REG_CTRL     = 6'd0,
    REG_PRESCALE = 6'd1,
    REG_COUNT    = 6'd2,
    REG_RELOAD   = 6'd3,
    REG_STATUS   = 6'd4,
    REG_CYCLES   = 6'd5
  } reg_e;

  logic                  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q, irq_d;
  logic                  en_q, en_d;
  logic                  auto_q, auto_d;
  logic                  ie_q, ie_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           reload_q, reload_d;
  logic                  exp_q, exp_d;
`ifdef PICOSOC_TIMER_CYCLES_EN
  logic [31:0]           cyc_q, cyc_d;
`endif

  logic        hit, sel, is_wr, wr_en, rd_en;
  logic        wr_ctrl, wr_presc, wr_count, wr_reload, wr_status;
  logic        tick, expire;
  logic [31:0] wmask;
  logic [31:0] rd_val;
  reg_e        idx;
  logic        unused_addr;

  assign unused_addr = ^iomem_addr[1:0];

  function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  // Bus decode: ready_q blocks a new select so accesses are spaced at least two cycles apart
  assign hit   = (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign sel   = iomem_valid & hit & ~ready_q;
  assign is_wr = |iomem_wstrb;
  assign wr_en = sel & is_wr;
  assign rd_en = sel & ~is_wr;
  assign idx   = reg_e'(iomem_addr[7:2]);
  assign wmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                  {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

  assign wr_ctrl   = wr_en & (idx == REG_CTRL);
  assign wr_presc  = wr_en & (idx == REG_PRESCALE);
  assign wr_count  = wr_en & (idx == REG_COUNT);
  assign wr_reload = wr_en & (idx == REG_RELOAD);
  assign wr_status = wr_en & (idx == REG_STATUS);

  assign tick   = en_q & (pcnt_q == presc_q);
  assign expire = tick & (count_q == 32'd1);

  always_comb begin
    rd_val = '0;
    case (idx)
      REG_CTRL:     rd_val[2:0] = {ie_q, auto_q, en_q};
      REG_PRESCALE: rd_val[PRESCALE_W-1:0] = presc_q;
      REG_COUNT:    rd_val = count_q;
      REG_RELOAD:   rd_val = reload_q;
      REG_STATUS:   rd_val[0] = exp_q;
`ifdef PICOSOC_TIMER_CYCLES_EN
      REG_CYCLES:   rd_val = cyc_q;
`endif
      default:      rd_val = '0;
    endcase
  end

  always_comb begin
    ready_d = sel;
    rdata_d = rd_en ? rd_val : '0;
    irq_d   = exp_q & ie_q;
  end

  // Hardware updates are applied first so CPU writes to the same register override them
  always_comb begin
    en_d     = en_q;
    auto_d   = auto_q;
    ie_d     = ie_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    count_d  = count_q;
    reload_d = reload_q;
    exp_d    = exp_q;

    if (!en_q || wr_presc || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end

    if (tick) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else if (count_q == 32'd1) begin
        if (auto_q) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          en_d    = 1'b0;
        end
      end
    end

    if (wr_ctrl && iomem_wstrb[0]) begin
      en_d   = iomem_wdata[0];
      auto_d = iomem_wdata[1];
      ie_d   = iomem_wdata[2];
    end
    if (wr_presc) begin
      presc_d = (presc_q & ~wmask[PRESCALE_W-1:0]) |
                (iomem_wdata[PRESCALE_W-1:0] & wmask[PRESCALE_W-1:0]);
    end
    if (wr_count) begin
      count_d = merge32(count_q, iomem_wdata, wmask);
    end
    if (wr_reload) begin
      reload_d = merge32(reload_q, iomem_wdata, wmask);
    end

    // A fresh expiry wins over a simultaneous write-1-to-clear
    if (wr_status && iomem_wstrb[0] && iomem_wdata[0]) begin
      exp_d = 1'b0;
    end
    if (expire) begin
      exp_d = 1'b1;
    end
  end

`ifdef PICOSOC_TIMER_CYCLES_EN
  always_comb begin
    cyc_d = cyc_q + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      ie_q     <= 1'b0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      count_q  <= '0;
      reload_q <= '0;
      exp_q    <= 1'b0;
`ifdef PICOSOC_TIMER_CYCLES_EN
      cyc_q    <= '0;
`endif
    end else begin
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      en_q     <= en_d;
      auto_q   <= auto_d;
      ie_q     <= ie_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      exp_q    <= exp_d;
`ifdef PICOSOC_TIMER_CYCLES_EN
      cyc_q    <= cyc_d;
`endif
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = irq_q;

endmodule
